// File: rtl/serial_adder.sv
// Multi-cycle WIDTH-bit adder iterating a DIGIT-bit full-adder slice LSB-first; optional subtract via SERIAL_ADDER_SUB_EN.
// Latency: WIDTH/DIGIT clock edges from accepted start to the done pulse; back-to-back start from DONE adds no idle cycle.
// Backpressure: start is ignored while busy (no queuing); results hold until the next completion.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    // a_sh doubles as the result register: operand bits leave at the bottom
    // while sum bits enter at the top, so after N slices it holds the result.
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] b_sel;
    logic             c_sel;

    // Operand conditioning at capture: subtraction is a + ~b + 1.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_sel = sub ? ~b : b;
    assign c_sel = sub ? 1'b1 : cin;
`else
    assign b_sel = b;
    assign c_sel = cin;
`endif

    logic [DIGIT:0]   slice;
    logic [DIGIT-1:0] s;
    logic             c_out;
    logic             c_msb;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_next;

    assign slice  = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    assign s      = slice[DIGIT-1:0];
    assign c_out  = slice[DIGIT];
    // Carry into the top bit of this slice; only meaningful on the last slice,
    // where that bit is the operand MSB.
    assign c_msb  = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ s[DIGIT-1];
    assign a_next = (a_sh >> DIGIT) | (WIDTH'(s) << (WIDTH - DIGIT));
    assign b_next = b_sh >> DIGIT;

    // Control FSM and datapath registers; all outputs registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b_sel;
                        carry <= c_sel;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh  <= a_next;
                    b_sh  <= b_next;
                    carry <= c_out;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum      <= a_next;
                        cout     <= c_out;
                        overflow <= c_msb ^ c_out;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 with DIGIT=1 and DIGIT=4 instances.
// Checks reset state, latency, results and flags, ignored mid-run start, mid-run reset.
// Outputs sampled 1 time unit after the rising edge; inputs driven with blocking assignments.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       cin = 1'b0;
    logic       busy, done, cout, overflow;
    logic [7:0] sum;

    logic       start4 = 1'b0;
    logic [7:0] a4 = '0, b4 = '0;
    logic       cin4 = 1'b0;
    logic       busy4, done4, cout4, overflow4;
    logic [7:0] sum4;

`ifdef SERIAL_ADDER_SUB_EN
    logic       sub = 1'b0;
    logic       sub4 = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .start    (start4),
        .a        (a4),
        .b        (b4),
        .cin      (cin4),
`ifdef SERIAL_ADDER_SUB_EN
        .sub      (sub4),
`endif
        .busy     (busy4),
        .done     (done4),
        .sum      (sum4),
        .cout     (cout4),
        .overflow (overflow4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one edge on the DIGIT=1 instance.
    task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Wait (bounded) for done, counting busy cycles, then check the result.
    task automatic collect(input string tag, input logic [7:0] es, input logic ec, input logic eo);
        int cyc = 0;
        int guard = 0;
        while (!done && guard < 20) begin
            if (busy) cyc++;
            step();
            guard++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_cycles"}, cyc, 8);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, cout, ec);
        check({tag, "_ovf"}, overflow, eo);
    endtask

    initial begin
        int pulses;
        logic [7:0] cap;

        // Reset state
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 8'h00);
        check("rst_cout", cout, 0);
        check("rst_ovf", overflow, 0);
        check("rst4_busy", busy4, 0);
        rst = 1'b0;

        // Basic add
        @(negedge clk);
        issue(8'h0F, 8'h01, 1'b0);
        collect("add_0f_01", 8'h10, 1'b0, 1'b0);

        // Back-to-back start in the DONE cycle: wrap with carry out
        issue(8'hFF, 8'h01, 1'b0);
        collect("add_ff_01", 8'h00, 1'b1, 1'b0);
        step();
        check("done_one_cycle", done, 0);
        check("idle_busy", busy, 0);
        check("idle_sum_hold", sum, 8'h00);

        // Carry-in driving positive overflow
        @(negedge clk);
        issue(8'h7F, 8'h00, 1'b1);
        collect("add_7f_00_c1", 8'h80, 1'b0, 1'b1);

        // Negative overflow with carry out
        @(negedge clk);
        issue(8'h80, 8'h80, 1'b0);
        collect("add_80_80", 8'h00, 1'b1, 1'b1);
        step();

        // start mid-RUN with new operands is ignored
        @(negedge clk);
        issue(8'h0F, 8'h01, 1'b0);
        repeat (3) step();
        check("run_busy", busy, 1);
        check("run_sum_stable", sum, 8'h00);
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        pulses = 0;
        cap = 8'h00;
        for (int i = 0; i < 14; i++) begin
            if (done) begin
                pulses++;
                cap = sum;
            end
            step();
        end
        check("midstart_pulses", pulses, 1);
        check("midstart_sum", cap, 8'h10);

        // Reset in RUN cycle 4 discards the operation
        @(negedge clk);
        issue(8'h0F, 8'h01, 1'b0);
        repeat (3) step();
        check("prerst_busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_sum", sum, 8'h00);
        check("midrst_cout", cout, 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) pulses++;
            step();
        end
        check("midrst_no_done", pulses, 0);
        check("midrst_sum_hold", sum, 8'h00);

        // Normal completion after reset
        @(negedge clk);
        issue(8'h0F, 8'h01, 1'b0);
        collect("post_rst", 8'h10, 1'b0, 1'b0);
        step();

        // DIGIT=4: two RUN edges
        @(negedge clk);
        a4 = 8'hAB; b4 = 8'h55; cin4 = 1'b0; start4 = 1'b1;
        step();
        start4 = 1'b0;
        check("d4_busy0", busy4, 1);
        check("d4_done0", done4, 0);
        step();
        check("d4_busy1", busy4, 1);
        check("d4_done1", done4, 0);
        step();
        check("d4_done", done4, 1);
        check("d4_busy_at_done", busy4, 0);
        check("d4_sum", sum4, 8'h00);
        check("d4_cout", cout4, 1);
        check("d4_ovf", overflow4, 0);
        step();
        check("d4_done_drop", done4, 0);

`ifdef SERIAL_ADDER_SUB_EN
        // Subtraction with borrow: 5 - 7
        @(negedge clk);
        sub = 1'b1;
        issue(8'h05, 8'h07, 1'b0);
        sub = 1'b0;
        collect("sub_05_07", 8'hFE, 1'b0, 1'b0);
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
